// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for mux2_rr_arbiter: two req/ack producers, one ready/valid consumer.
// The master side drives requests and data; the slave side is the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 1
) ();
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             out_ready;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] z;
  logic             z_valid;

  modport master (
    output req0, req1, d0, d1, out_ready,
    input  gnt0, gnt1, sel, ack0, ack1, z, z_valid
  );

  modport slave (
    input  req0, req1, d0, d1, out_ready,
    output gnt0, gnt1, sel, ack0, ack1, z, z_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-limited arbiter that shares a WIDTH-bit bank of mux2 cells
// between two req/ack producers. The mux result is registered as z/z_valid.

module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);
  assign y = s ? d1 : d0;
endmodule

module mux2_rr_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);
  localparam int STAGES = 1;
  localparam int BW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic [BW-1:0]    burst_q;
  logic             sel_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] mux_y;
  logic [STAGES:0]  vld_pipe;
  logic             ack0, ack1, xfer, burst_end;
  logic             enter0, enter1;

  assign ack0      = (state_q == GNT0) & bus.req0 & bus.out_ready;
  assign ack1      = (state_q == GNT1) & bus.req1 & bus.out_ready;
  assign xfer      = ack0 | ack1;
  assign burst_end = (burst_q == BLAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? GNT0 : GNT1;
        else if (bus.req0)        state_d = GNT0;
        else if (bus.req1)        state_d = GNT1;
      end
      GNT0: begin
        // a dropped request releases the grant even under back-pressure
        if (!bus.req0)                           state_d = bus.req1 ? GNT1 : IDLE;
        else if (ack0 && burst_end && bus.req1)  state_d = GNT1;
      end
      GNT1: begin
        if (!bus.req1)                           state_d = bus.req0 ? GNT0 : IDLE;
        else if (ack1 && burst_end && bus.req0)  state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter0 = (state_d == GNT0) && (state_q != GNT0);
  assign enter1 = (state_d == GNT1) && (state_q != GNT1);

  // sel only moves on grant entry, so the mux select is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter0) begin
        last_q  <= 1'b0;
        burst_q <= '0;
        sel_q   <= 1'b0;
      end else if (enter1) begin
        last_q  <= 1'b1;
        burst_q <= '0;
        sel_q   <= 1'b1;
      end else if (xfer) begin
        burst_q <= burst_end ? '0 : burst_q + BW'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux2 u_mux (
      .d0 (bus.d0[i]),
      .d1 (bus.d1[i]),
      .s  (sel_q),
      .y  (mux_y[i])
    );
  end

  assign vld_pipe[0] = xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q                <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      if (xfer) z_q <= mux_y;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign bus.gnt0    = (state_q == GNT0);
  assign bus.gnt1    = (state_q == GNT1);
  assign bus.sel     = sel_q;
  assign bus.ack0    = ack0;
  assign bus.ack1    = ack1;
  assign bus.z       = z_q;
  assign bus.z_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, tie-break, burst rotation,
// back-pressure, grant release and single transfer, with hand-computed values.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.d0 = '0; bus.d1 = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_zv", bus.z_valid, 0);
    cyc; cyc;
    rst_n = 1'b1;

    // first tie after reset goes to requester 0, then 4/4 rotation
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk("idle_noack0", bus.ack0, 0);
    chk("idle_noack1", bus.ack1, 0);
    cyc;
    chk("tie_gnt0", bus.gnt0, 1);
    chk("tie_gnt1", bus.gnt1, 0);
    prev = 8'h00;
    for (int k = 0; k < 10; k++) begin
      bus.d0 = 8'(k);
      bus.d1 = 8'(8'h80 + k);
      #1;
      chk($sformatf("rr_ack0_%0d", k), bus.ack0, ((k / 4) % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_ack1_%0d", k), bus.ack1, ((k / 4) % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_sel_%0d", k), bus.sel, (k / 4) % 2);
      chk($sformatf("rr_zv_%0d", k), bus.z_valid, (k > 0) ? 1 : 0);
      if (k > 0) chk($sformatf("rr_z_%0d", k), bus.z, prev);
      prev = ((k / 4) % 2 == 1) ? 8'(8'h80 + k) : 8'(k);
      cyc;
    end

    // GNT0 with burst 2: req0 drops, grant moves to 1 with no transfer from 0
    bus.req0 = 1'b0; bus.d0 = 8'hEE;
    #1;
    chk("rel_ack0", bus.ack0, 0);
    chk("rel_zv_prev", bus.z_valid, 1);
    chk("rel_z_prev", bus.z, 8'h09);
    cyc;
    bus.req0 = 1'b1; bus.d1 = 8'hC0;
    #1;
    chk("rel_gnt1", bus.gnt1, 1);
    chk("rel_sel", bus.sel, 1);
    chk("rel_zv", bus.z_valid, 0);
    chk("rel_zhold", bus.z, 8'h09);
    chk("rel_ack1", bus.ack1, 1);
    cyc;
    bus.d1 = 8'hC1;
    #1;
    chk("g1_ack1b", bus.ack1, 1);
    chk("g1_z", bus.z, 8'hC0);
    cyc;

    // back-pressure in GNT1 at burst 2
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      bus.d1 = 8'(8'hF0 + i);
      #1;
      chk($sformatf("bp_ack1_%0d", i), bus.ack1, 0);
      chk($sformatf("bp_gnt1_%0d", i), bus.gnt1, 1);
      chk($sformatf("bp_sel_%0d", i), bus.sel, 1);
      chk($sformatf("bp_zv_%0d", i), bus.z_valid, (i == 0) ? 1 : 0);
      chk($sformatf("bp_z_%0d", i), bus.z, 8'hC1);
      cyc;
    end
    // burst count held at 2: exactly two more transfers before switching
    for (int i = 0; i < 2; i++) begin
      bus.out_ready = 1'b1;
      bus.d1 = 8'(8'hD0 + i);
      #1;
      chk($sformatf("bpr_ack1_%0d", i), bus.ack1, 1);
      chk($sformatf("bpr_zv_%0d", i), bus.z_valid, (i == 1) ? 1 : 0);
      chk($sformatf("bpr_z_%0d", i), bus.z, (i == 0) ? 8'hC1 : 8'hD0);
      cyc;
    end
    bus.d0 = 8'h33;
    #1;
    chk("sw_gnt0", bus.gnt0, 1);
    chk("sw_sel", bus.sel, 0);
    chk("sw_ack0", bus.ack0, 1);
    chk("sw_z", bus.z, 8'hD1);
    cyc;

    // reach GNT1 with z_valid high, then reset mid-burst
    bus.req0 = 1'b0; bus.d1 = 8'h77;
    #1;
    chk("pre_z", bus.z, 8'h33);
    cyc;
    #1;
    chk("pre_gnt1", bus.gnt1, 1);
    chk("pre_ack1", bus.ack1, 1);
    cyc;
    chk("pre_zv", bus.z_valid, 1);
    chk("pre_z77", bus.z, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt1", bus.gnt1, 0);
    chk("mrst_sel", bus.sel, 0);
    chk("mrst_z", bus.z, 0);
    chk("mrst_zv", bus.z_valid, 0);
    bus.req1 = 1'b0;
    cyc;
    rst_n = 1'b1;

    // single transfer from requester 0
    bus.req0 = 1'b1; bus.d0 = 8'hA5; bus.out_ready = 1'b1;
    #1;
    chk("s_noack", bus.ack0, 0);
    cyc;
    chk("s_gnt0", bus.gnt0, 1);
    chk("s_ack0", bus.ack0, 1);
    cyc;
    bus.req0 = 1'b0;
    #1;
    chk("s_z", bus.z, 8'hA5);
    chk("s_zv", bus.z_valid, 1);
    chk("s_ack0_off", bus.ack0, 0);
    cyc;
    chk("s_idle", bus.gnt0, 0);
    chk("s_zv_off", bus.z_valid, 0);
    chk("s_zhold", bus.z, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
